// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: opcode map, FSM state codes,
// stack-operation codes and the decoded instruction class.
package cu_pkg;

  localparam logic [5:0] OP_BRZ   = 6'h00;
  localparam logic [5:0] OP_BRN   = 6'h01;
  localparam logic [5:0] OP_BRC   = 6'h02;
  localparam logic [5:0] OP_BRO   = 6'h03;
  localparam logic [5:0] OP_LOAD  = 6'h04;
  localparam logic [5:0] OP_STORE = 6'h05;
  localparam logic [5:0] OP_BRA   = 6'h06;
  localparam logic [5:0] OP_JMP   = 6'h07;
  localparam logic [5:0] OP_RET   = 6'h08;
  localparam logic [5:0] OP_MUL   = 6'h10;
  localparam logic [5:0] OP_DIV   = 6'h11;
  localparam logic [5:0] OP_MOD   = 6'h12;
  localparam logic [5:0] OP_LAST  = 6'h1A;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DECODE   = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_MEM      = 3'd3;
  localparam logic [2:0] ST_WAIT_ALU = 3'd4;
  localparam logic [2:0] ST_TRAP     = 3'd5;

  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;

  typedef enum logic [2:0] {
    CL_COND  = 3'd0,
    CL_BRA   = 3'd1,
    CL_JMP   = 3'd2,
    CL_RET   = 3'd3,
    CL_LOAD  = 3'd4,
    CL_STORE = 3'd5,
    CL_ALU   = 3'd6,
    CL_LONG  = 3'd7
  } op_class_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: class, branch condition select, long-op flag
// and legality of the captured opcode.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class,
  output logic [1:0]     cond_sel,
  output logic           is_long,
  output logic           legal
);

  logic [5:0] low;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    low      = opcode[5:0];
    op_class = CL_ALU;
    is_long  = 1'b0;
    // cond_sel indexes flags {O,C,N,Z}: brz->Z(0), brn->N(1), brc->C(2), bro->O(3)
    cond_sel = low[1:0];
    // Any non-zero bit above [5:0] also pushes the value past OP_LAST.
    legal    = (opcode <= OPW'(OP_LAST));

    if (low <= OP_BRO) begin
      op_class = CL_COND;
    end else if (low == OP_LOAD) begin
      op_class = CL_LOAD;
    end else if (low == OP_STORE) begin
      op_class = CL_STORE;
    end else if (low == OP_BRA) begin
      op_class = CL_BRA;
    end else if (low == OP_JMP) begin
      op_class = CL_JMP;
    end else if (low == OP_RET) begin
      op_class = CL_RET;
    end else if (low >= OP_MUL && low <= OP_MOD) begin
      op_class = CL_LONG;
      is_long  = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle control unit FSM. Every output is a flop loaded on the edge that
// enters the state in which it is visible.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int FLW         = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [FLW-1:0] flags,
  output logic           mem_req,
  output logic           mem_we,
  input  logic           mem_ack,
  output logic           alu_start,
  input  logic           alu_done,
  output logic           acc_load,
  output logic           pc_load,
  output logic           pc_inc,
  output logic [1:0]     sp_op,
  output logic           illegal
);

  localparam int CNTW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
  logic            instr_ready_q, instr_ready_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic            alu_start_q, alu_start_d;
  logic            acc_load_q, acc_load_d;
  logic            pc_load_q, pc_load_d;
  logic            pc_inc_q, pc_inc_d;
  logic [1:0]      sp_op_q, sp_op_d;
  logic            illegal_q, illegal_d;

  op_class_e  op_class;
  logic [1:0] cond_sel;
  logic       is_long;
  logic       legal;

  cu_decoder #(.OPW(OPW)) u_decoder (
    .opcode   (opcode_q),
    .op_class (op_class),
    .cond_sel (cond_sel),
    .is_long  (is_long),
    .legal    (legal)
  );

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    wait_cnt_d    = '0;
    instr_ready_d = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    alu_start_d   = 1'b0;
    acc_load_d    = 1'b0;
    pc_load_d     = 1'b0;
    pc_inc_d      = 1'b0;
    sp_op_d       = SP_NONE;
    illegal_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          opcode_d = opcode;
          state_d  = ST_DECODE;
        end else begin
          instr_ready_d = 1'b1;
        end
      end

      // Outputs seen during EXEC are decided here; the branch flag is taken
      // on the edge that enters EXEC so pc_load/pc_inc are valid in EXEC.
      ST_DECODE: begin
        if (!legal) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
          if (is_long) begin
            alu_start_d = 1'b1;
          end else begin
            case (op_class)
              CL_COND: begin
                if (flags[cond_sel]) pc_load_d = 1'b1;
                else                 pc_inc_d  = 1'b1;
              end
              CL_BRA:  pc_load_d = 1'b1;
              CL_JMP: begin
                pc_load_d = 1'b1;
                sp_op_d   = SP_PUSH;
              end
              CL_RET: begin
                pc_load_d = 1'b1;
                sp_op_d   = SP_POP;
              end
              CL_LOAD:  mem_req_d = 1'b1;
              CL_STORE: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
              end
              default: begin
                acc_load_d = 1'b1;
                pc_inc_d   = 1'b1;
              end
            endcase
          end
        end
      end

      ST_EXEC: begin
        if (op_class == CL_LOAD || op_class == CL_STORE) begin
          state_d   = ST_MEM;
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end else if (is_long) begin
          state_d = ST_WAIT_ALU;
        end else begin
          state_d       = ST_IDLE;
          instr_ready_d = 1'b1;
        end
      end

      // An ack in the cycle the timeout is reached still completes the access.
      ST_MEM: begin
        if (mem_ack) begin
          state_d       = ST_IDLE;
          instr_ready_d = 1'b1;
          pc_inc_d      = 1'b1;
          acc_load_d    = (op_class == CL_LOAD);
        end else begin
          wait_cnt_d = wait_cnt_q + CNTW'(1);
          if (wait_cnt_d == CNTW'(MEM_TIMEOUT)) begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = mem_we_q;
          end
        end
      end

      ST_WAIT_ALU: begin
        if (alu_done) begin
          state_d       = ST_IDLE;
          instr_ready_d = 1'b1;
          acc_load_d    = 1'b1;
          pc_inc_d      = 1'b1;
        end
      end

      ST_TRAP: begin
        illegal_d = 1'b1;
      end

      default: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      wait_cnt_q    <= '0;
      instr_ready_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      alu_start_q   <= 1'b0;
      acc_load_q    <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_inc_q      <= 1'b0;
      sp_op_q       <= SP_NONE;
      illegal_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_ready_q <= instr_ready_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      alu_start_q   <= alu_start_d;
      acc_load_q    <= acc_load_d;
      pc_load_q     <= pc_load_d;
      pc_inc_q      <= pc_inc_d;
      sp_op_q       <= sp_op_d;
      illegal_q     <= illegal_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign alu_start   = alu_start_q;
  assign acc_load    = acc_load_q;
  assign pc_load     = pc_load_q;
  assign pc_inc      = pc_inc_q;
  assign sp_op       = sp_op_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 The block SHALL provide parameter OPW, default 6, meaning opcode width in bits (minimum 6; bits above [5:0] non-zero make the opcode illegal).
REQ-002 The block SHALL provide parameter MEM_TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_ack before trapping.
REQ-003 The block SHALL provide parameter FLW, default 4, meaning flag width, ordered {O,C,N,Z} from MSB to LSB.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 instr_valid  input  1  an opcode is offered.
REQ-007 instr_ready  output  1  the CU accepts an opcode this cycle.
REQ-008 opcode  input  OPW  instruction opcode.
REQ-009 flags  input  FLW  ALU status flags.
REQ-010 mem_req  output  1  memory access request, held until ack.
REQ-011 mem_we  output  1  write qualifier for mem_req (1 = store).
REQ-012 mem_ack  input  1  memory access complete.
REQ-013 alu_start  output  1  one-cycle start pulse for a multi-cycle ALU op.
REQ-014 alu_done  input  1  multi-cycle ALU result ready.
REQ-015 acc_load, pc_load, pc_inc  outputs  1 each  one-cycle write-enable pulses.
REQ-016 sp_op  output  2  stack operation: 00 none, 01 push, 10 pop.
REQ-017 illegal  output  1  sticky trap indicator.

Function
REQ-018 All outputs SHALL be registered, so each one is a function of the current state only.
REQ-019 States: IDLE, DECODE, EXEC, MEM, WAIT_ALU, TRAP.
REQ-020 IDLE SHALL drive instr_ready=1; on instr_valid&&instr_ready it SHALL capture opcode and go to DECODE; otherwise it stays in IDLE.
REQ-021 DECODE SHALL last one cycle: an opcode above 0x1A, or with non-zero upper bits, goes to TRAP; any other opcode goes to EXEC.
REQ-022 Opcode map: 0x00-0x03 brz/brn/brc/bro; 0x04 load; 0x05 store; 0x06 bra; 0x07 jmp; 0x08 ret; 0x09-0x1A ALU/mov.
REQ-023 EXEC, conditional branch: the tested flag (brz→Z, brn→N, brc→C, bro→O) SHALL be sampled in EXEC; set → pc_load, clear → pc_inc; next state IDLE.
REQ-024 EXEC, bra: pc_load; next state IDLE.
REQ-025 EXEC, jmp: pc_load with sp_op=01; next state IDLE.
REQ-026 EXEC, ret: pc_load with sp_op=10; next state IDLE.
REQ-027 EXEC, load/store: mem_req=1 (mem_we=1 for store) and go to MEM.
REQ-028 EXEC, mul/div/mod (0x10-0x12): alu_start pulse and go to WAIT_ALU.
REQ-029 EXEC, other ALU/mov opcodes: acc_load and pc_inc pulse, then IDLE.
REQ-030 EXEC SHALL complete the simple ALU/mov/branch opcodes in one cycle: capture edge N, DECODE N+1, EXEC N+2, IDLE N+3.
REQ-031 MEM SHALL hold mem_req (and mem_we) until mem_ack; on ack it pulses pc_inc, pulses acc_load for load only, and goes to IDLE.
REQ-032 MEM SHALL clear a 4-bit-minimum wait counter on entry; if the counter reaches MEM_TIMEOUT without ack, the CU goes to TRAP.
REQ-033 If mem_ack arrives in the same cycle the timeout is reached, the ack SHALL take priority.
REQ-034 alu_done SHALL be sampled only in WAIT_ALU; on alu_done the CU pulses acc_load and pc_inc and goes to IDLE. WAIT_ALU has no timeout.
REQ-035 TRAP SHALL hold illegal=1 and instr_ready=0 with all pulses at 0, and SHALL be left only by rst.
REQ-036 instr_ready SHALL be 0 in every state except IDLE, so opcode changes outside IDLE are ignored.

Reset
REQ-037 While rst is high: state=IDLE, all pulse outputs 0, mem_req=0, mem_we=0, sp_op=00, illegal=0, instr_ready=0, wait counter 0.
REQ-038 After rst releases, instr_ready SHALL rise on the first clock edge.
REQ-039 rst asserted mid-MEM or mid-WAIT_ALU SHALL abort the instruction with no further pulses.

Structure
REQ-040 Package cu_pkg SHALL hold the opcode localparams, the state enum, and the sp_op encodings.
REQ-041 Sub-module cu_decoder (combinational) SHALL map the captured opcode to {class, cond_sel, is_long, legal}.
REQ-042 The FSM and its counter SHALL live in multicycle_cu.

Verification
REQ-043 Opcode 0x09, valid for 1 cycle → acc_load and pc_inc high exactly at cycle N+2; instr_ready back to 1 at N+3.
REQ-044 brz with flags=4'b0001 → pc_load=1 and pc_inc=0; brz with flags=4'b0000 → pc_inc=1 and pc_load=0.
REQ-045 load with mem_ack delayed 5 cycles → mem_req held 5 cycles, mem_we=0, then acc_load for one cycle; store with no ack → illegal=1 after 15 wait cycles.
REQ-046 mul with alu_done after 8 cycles → exactly one alu_start pulse, then acc_load one cycle after done; jmp → sp_op=01; ret → sp_op=10.
REQ-047 Opcode 0x1B → illegal=1 and instr_ready stays 0 through 20 cycles; rst then clears both, and instr_ready=1 on the next clock edge.
REQ-048 rst asserted during WAIT_ALU → all outputs 0 immediately, and a later alu_done produces no acc_load.
